// File: rtl/multiplicador_booth_r4.sv
// Sequential radix-4 (modified Booth) multiplier, NUM_BITS-wide operands, signed/unsigned at runtime.
// Optional macro MULT_EARLY_EXIT_EN finishes early once every remaining Booth digit is zero.
module multiplicador_booth_r4 #(
  parameter int NUM_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    signo,
  input  logic [NUM_BITS-1:0]     multiplicando,
  input  logic [NUM_BITS-1:0]     multiplicador,
  output logic [2*NUM_BITS-1:0]   resultado,
  output logic                    Fin,
  output logic                    ocupado
);

  localparam int E    = (NUM_BITS % 2 == 0) ? NUM_BITS + 2 : NUM_BITS + 1;
  localparam int ITER = E / 2;
  localparam int AW   = E + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  r_state;
  logic [AW-1:0]           r_a;
  logic [AW-1:0]           r_m;
  logic [E-1:0]            r_q;
  logic                    r_q1;
  logic [CW-1:0]           r_cnt;
  logic [2*NUM_BITS-1:0]   r_resultado;
  logic                    r_fin;
  logic                    r_ocupado;

  logic [AW-1:0]           w_m_ext;
  logic [E-1:0]            w_q_ext;
  logic [2:0]              w_digit;
  logic [AW-1:0]           w_addend;
  logic [AW-1:0]           w_sum;
  logic [AW-1:0]           w_a_next;
  logic [E-1:0]            w_q_next;
  logic                    w_q1_next;
  logic [2*E+1:0]          w_full;
  logic [2*E+1:0]          w_shifted;
  logic [7:0]              w_shamt;
  logic                    w_last;

  assign w_m_ext = {{(AW-NUM_BITS){signo & multiplicando[NUM_BITS-1]}}, multiplicando};
  assign w_q_ext = {{(E-NUM_BITS){signo & multiplicador[NUM_BITS-1]}}, multiplicador};

  always_comb begin
    w_digit  = {r_q[1:0], r_q1};
    w_addend = '0;
    case (w_digit)
      3'b001, 3'b010: w_addend = r_m;
      3'b011:         w_addend = {r_m[AW-2:0], 1'b0};
      3'b100:         w_addend = -{r_m[AW-2:0], 1'b0};
      3'b101, 3'b110: w_addend = -r_m;
      default:        w_addend = '0;
    endcase
    w_sum     = r_a + w_addend;
    w_a_next  = {w_sum[AW-1], w_sum[AW-1], w_sum[AW-1:2]};
    w_q_next  = {w_sum[1:0], r_q[E-1:2]};
    w_q1_next = r_q[1];
  end

  // When the unretired multiplier bits are uniform, the rest of the work is a pure arithmetic shift.
  always_comb begin
    w_last  = (r_cnt == CW'(ITER - 1));
    w_shamt = '0;
`ifdef MULT_EARLY_EXIT_EN
    begin
      logic [E:0] w_rem;
      logic       w_uniform;
      w_rem     = {w_q_next, w_q1_next};
      w_uniform = 1'b1;
      for (int i = 1; i <= E; i++) begin
        if ((i <= E - 2 * (int'(r_cnt) + 1)) && (w_rem[i] != w_rem[0]))
          w_uniform = 1'b0;
      end
      if (w_uniform) begin
        w_last  = 1'b1;
        w_shamt = 8'(2 * (ITER - 1 - int'(r_cnt)));
      end
    end
`endif
    w_full    = {w_a_next, w_q_next};
    w_shifted = $signed(w_full) >>> w_shamt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_q1        <= 1'b0;
      r_cnt       <= '0;
      r_resultado <= '0;
      r_fin       <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_fin <= 1'b0;
          if (start) begin
            r_state   <= S_CALC;
            r_a       <= '0;
            r_m       <= w_m_ext;
            r_q       <= w_q_ext;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
          end else begin
            r_state   <= S_IDLE;
            r_ocupado <= 1'b0;
          end
        end
        S_CALC: begin
          r_a  <= w_a_next;
          r_q  <= w_q_next;
          r_q1 <= w_q1_next;
          if (w_last) begin
            r_state     <= S_DONE;
            r_resultado <= w_shifted[2*NUM_BITS-1:0];
            r_fin       <= 1'b1;
            r_ocupado   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_fin     <= 1'b0;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign resultado = r_resultado;
  assign Fin       = r_fin;
  assign ocupado   = r_ocupado;

endmodule

// File: tb/tb_multiplicador_booth_r4.sv
// Self-checking bench for multiplicador_booth_r4 (NUM_BITS=4 and NUM_BITS=5 instances).
// Expected latencies follow MULT_EARLY_EXIT_EN when that macro is defined.
module tb_multiplicador_booth_r4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start4 = 1'b0, signo4 = 1'b0;
  logic [3:0] mcand4 = '0, mplier4 = '0;
  logic [7:0] res4;
  logic       fin4, ocup4;

  logic       start5 = 1'b0, signo5 = 1'b0;
  logic [4:0] mcand5 = '0, mplier5 = '0;
  logic [9:0] res5;
  logic       fin5, ocup5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplicador_booth_r4 #(.NUM_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signo(signo4),
    .multiplicando(mcand4), .multiplicador(mplier4),
    .resultado(res4), .Fin(fin4), .ocupado(ocup4)
  );

  multiplicador_booth_r4 #(.NUM_BITS(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .signo(signo5),
    .multiplicando(mcand5), .multiplicador(mplier5),
    .resultado(res5), .Fin(fin5), .ocupado(ocup5)
  );

  // Exact product of the n-bit operands, reduced modulo 2^(2n).
  function automatic logic [9:0] ref_prod(int n, bit s, logic [4:0] a, logic [4:0] b);
    longint av, bv, p;
    av = longint'(a) & ((longint'(1) << n) - 1);
    bv = longint'(b) & ((longint'(1) << n) - 1);
    if (s && a[n-1]) av = av - (longint'(1) << n);
    if (s && b[n-1]) bv = bv - (longint'(1) << n);
    p = av * bv;
    return 10'(p & ((longint'(1) << (2 * n)) - 1));
  endfunction

  // Edges from start sample to Fin, counting the sampling edge.
  function automatic int exp_lat(int n, bit s, logic [4:0] b);
    int e, iter;
    e    = (n % 2 == 0) ? n + 2 : n + 1;
    iter = e / 2;
`ifdef MULT_EARLY_EXIT_EN
    begin
      logic [7:0] ext;
      bit same;
      for (int i = 0; i < 8; i++) ext[i] = (i < n) ? b[i] : (s & b[n-1]);
      for (int k = 1; k < iter; k++) begin
        same = 1'b1;
        for (int i = 2 * k - 1; i < e; i++) if (ext[i] != ext[e-1]) same = 1'b0;
        if (same) return k + 1;
      end
    end
`endif
    return iter + 1;
  endfunction

  task automatic run_op(input bit use5, input bit s, input logic [4:0] a, input logic [4:0] b,
                        output logic [9:0] res, output int lat);
    bit done;
    @(negedge clk);
    if (use5) begin
      signo5 = s; mcand5 = a; mplier5 = b; start5 = 1'b1;
    end else begin
      signo4 = s; mcand4 = a[3:0]; mplier4 = b[3:0]; start4 = 1'b1;
    end
    @(posedge clk); #1;
    start4 = 1'b0; start5 = 1'b0;
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      done = use5 ? fin5 : fin4;
    end
    res = use5 ? res5 : {2'b00, res4};
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL op_timeout: no Fin within %0d edges (a=%0h b=%0h)", lat, a, b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks += 6;
    if (res4 !== 8'h00) begin errors++; $display("[TB] FAIL reset_res4: got %h want 00", res4); end
    if (fin4 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_fin4: got %b want 0", fin4); end
    if (ocup4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocup4: got %b want 0", ocup4); end
    if (res5 !== 10'h0) begin errors++; $display("[TB] FAIL reset_res5: got %h want 000", res5); end
    if (fin5 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_fin5: got %b want 0", fin5); end
    if (ocup5 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocup5: got %b want 0", ocup5); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_exhaustive4(input bit s);
    logic [9:0] res, exp;
    int lat, elat;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_op(1'b0, s, 5'(ai), 5'(bi), res, lat);
        exp  = ref_prod(4, s, 5'(ai), 5'(bi));
        elat = exp_lat(4, s, 5'(bi));
        checks += 2;
        if (res[7:0] !== exp[7:0]) begin
          errors++;
          $display("[TB] FAIL exh4_result s=%0d a=%h b=%h: got %h want %h", s, ai[3:0], bi[3:0], res[7:0], exp[7:0]);
        end
        if (lat !== elat) begin
          errors++;
          $display("[TB] FAIL exh4_latency s=%0d a=%h b=%h: got %0d want %0d", s, ai[3:0], bi[3:0], lat, elat);
        end
      end
    end
  endtask

  task automatic test_spots();
    logic [9:0] res;
    int lat;
    run_op(1'b0, 1'b1, 5'h08, 5'h08, res, lat); checks++;
    if (res[7:0] !== 8'h40) begin errors++; $display("[TB] FAIL spot_m8xm8: got %h want 40", res[7:0]); end
    run_op(1'b0, 1'b1, 5'h08, 5'h07, res, lat); checks++;
    if (res[7:0] !== 8'hC8) begin errors++; $display("[TB] FAIL spot_m8x7: got %h want c8", res[7:0]); end
    run_op(1'b0, 1'b0, 5'h0F, 5'h0F, res, lat); checks++;
    if (res[7:0] !== 8'hE1) begin errors++; $display("[TB] FAIL spot_15x15: got %h want e1", res[7:0]); end
    run_op(1'b0, 1'b0, 5'h0F, 5'h01, res, lat); checks++;
    if (res[7:0] !== 8'h0F) begin errors++; $display("[TB] FAIL spot_15x1: got %h want 0f", res[7:0]); end
    run_op(1'b1, 1'b1, 5'h10, 5'h10, res, lat); checks++;
    if (res !== 10'h100) begin errors++; $display("[TB] FAIL spot5_m16xm16: got %h want 100", res); end
    run_op(1'b1, 1'b0, 5'h1F, 5'h1F, res, lat); checks += 2;
    if (res !== 10'h3C1) begin errors++; $display("[TB] FAIL spot5_31x31: got %h want 3c1", res); end
    if (lat !== exp_lat(5, 1'b0, 5'h1F)) begin
      errors++; $display("[TB] FAIL spot5_31x31_latency: got %0d want %0d", lat, exp_lat(5, 1'b0, 5'h1F));
    end
  endtask

  task automatic test_random5();
    logic [9:0] res, exp;
    logic [4:0] a, b;
    bit s;
    int lat, elat;
    for (int n = 0; n < 60; n++) begin
      a = 5'($urandom);
      b = 5'($urandom);
      s = 1'($urandom);
      run_op(1'b1, s, a, b, res, lat);
      exp  = ref_prod(5, s, a, b);
      elat = exp_lat(5, s, b);
      checks += 2;
      if (res !== exp) begin
        errors++; $display("[TB] FAIL rand5_result s=%0d a=%h b=%h: got %h want %h", s, a, b, res, exp);
      end
      if (lat !== elat) begin
        errors++; $display("[TB] FAIL rand5_latency s=%0d a=%h b=%h: got %0d want %0d", s, a, b, lat, elat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, elat, extra;
    elat = exp_lat(4, 1'b0, 5'd5);
    @(negedge clk);
    signo4 = 1'b0; mcand4 = 4'd3; mplier4 = 4'd5; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; mcand4 = 4'd7; mplier4 = 4'd7;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 2;
    checks++;
    if (fin4 === 1'b1) begin
      errors++; $display("[TB] FAIL ignore_no_early_fin: Fin got 1 want 0 at edge 2");
    end else begin
      while (fin4 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      if (fin4 !== 1'b1) begin errors++; $display("[TB] FAIL ignore_timeout: no Fin within %0d edges", lat); end
    end
    checks += 2;
    if (lat !== elat) begin errors++; $display("[TB] FAIL ignore_latency: got %0d want %0d", lat, elat); end
    if (res4 !== 8'h0F) begin errors++; $display("[TB] FAIL ignore_result: got %h want 0f", res4); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (fin4 === 1'b1) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL ignore_no_second_op: got %0d Fin pulses want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    @(negedge clk);
    signo4 = 1'b0; mcand4 = 4'd2; mplier4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    mcand4 = 4'd4; mplier4 = 4'd4;
    lat1 = 1;
    while (fin4 !== 1'b1 && lat1 < 20) begin @(posedge clk); #1; lat1++; end
    checks += 2;
    if (lat1 !== exp_lat(4, 1'b0, 5'd3)) begin
      errors++; $display("[TB] FAIL b2b_lat1: got %0d want %0d", lat1, exp_lat(4, 1'b0, 5'd3));
    end
    if (res4 !== 8'h06) begin errors++; $display("[TB] FAIL b2b_res1: got %h want 06", res4); end
    @(posedge clk); #1;
    start4 = 1'b0;
    checks += 3;
    if (ocup4 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b want 1", ocup4); end
    if (fin4 !== 1'b0)  begin errors++; $display("[TB] FAIL b2b_fin_low: got %b want 0", fin4); end
    if (res4 !== 8'h06) begin errors++; $display("[TB] FAIL b2b_res_held: got %h want 06", res4); end
    lat2 = 1;
    while (fin4 !== 1'b1 && lat2 < 20) begin @(posedge clk); #1; lat2++; end
    checks += 2;
    if (lat2 !== exp_lat(4, 1'b0, 5'd4)) begin
      errors++; $display("[TB] FAIL b2b_lat2: got %0d want %0d", lat2, exp_lat(4, 1'b0, 5'd4));
    end
    if (res4 !== 8'h10) begin errors++; $display("[TB] FAIL b2b_res2: got %h want 10", res4); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] res;
    int lat, pulses;
    @(negedge clk);
    signo4 = 1'b0; mcand4 = 4'd5; mplier4 = 4'd6; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (res4 !== 8'h00) begin errors++; $display("[TB] FAIL midreset_res: got %h want 00", res4); end
    if (fin4 !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_fin: got %b want 0", fin4); end
    if (ocup4 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b want 0", ocup4); end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (fin4 === 1'b1) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL midreset_no_fin: got %0d pulses want 0", pulses); end
    run_op(1'b0, 1'b0, 5'd7, 5'd7, res, lat);
    checks += 2;
    if (res[7:0] !== 8'h31) begin errors++; $display("[TB] FAIL midreset_next_res: got %h want 31", res[7:0]); end
    if (lat !== exp_lat(4, 1'b0, 5'd7)) begin
      errors++; $display("[TB] FAIL midreset_next_lat: got %0d want %0d", lat, exp_lat(4, 1'b0, 5'd7));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_exhaustive4(1'b1);
    test_exhaustive4(1'b0);
    test_spots();
    test_random5();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
